dac_scan_seq: RTL
=================

Name: dac_scan_seq

Overview:
- Upstream controller for the sigma-delta threshold DAC.
- Generates the DAC's rst_dac and inc_dac strobes to walk it through its step table.
- At each step it waits a settle time, then counts discriminator hits over a fixed window and reports one result per step over a valid/ready handshake.
- Sits between the run-control logic and the DAC/readout path, and is used for threshold scans.

Parameters:
- NUM_STEPS, 9: DAC steps per scan (1..15). The DAC table wraps 9 to 1, so 9 covers one full pass.
- PULSE_W, 4: width in clk cycles of each rst_dac/inc_dac high pulse and of the low gap after inc_dac (>=1).
- SETTLE_CYC, 256: cycles waited after the inc_dac gap before counting (>=1).
- WINDOW_CYC, 1024: measurement window length in cycles (>=1).
- CNT_W, 16: hit counter width.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: one-cycle scan request; honoured only in IDLE.
- abort, in, 1: terminate scan; has priority over all other inputs except rst.
- hit_in, in, 1: discriminator output; each rising edge is one hit.
- rst_dac, out, 1: DAC step-pointer reset pulse; registered output.
- inc_dac, out, 1: DAC step-advance pulse; registered; the DAC treats it as a clock edge.
- step_idx, out, 4: current step, 1..NUM_STEPS; 0 when not scanning.
- res_count, out, CNT_W: hit count of the reported step.
- res_step, out, 4: step number of the reported result.
- res_valid, out, 1: result valid.
- res_ready, in, 1: consumer accepts the result.
- busy, out, 1: high in every state except IDLE and DONE.
- done, out, 1: high in DONE until the next accepted start, abort, or rst.

Behaviour:
- Reset (synchronous, in any state):
  - State returns to IDLE.
  - rst_dac, inc_dac, res_valid, busy and done go to 0.
  - step_idx, res_count, res_step and all counters go to 0.
- FSM states: IDLE, CLR, INC, GAP, SETTLE, MEAS, REPORT, DONE.
- IDLE: start=1 moves to CLR on the next edge. Clears done, step_idx=0.
- CLR: rst_dac=1 for exactly PULSE_W cycles, then INC.
- INC: inc_dac=1 for exactly PULSE_W cycles. step_idx increments on entry to INC, so the first step is 1. Then GAP.
- GAP: inc_dac=0 for PULSE_W cycles, then SETTLE.
- SETTLE: lasts SETTLE_CYC cycles, then MEAS.
- MEAS: lasts WINDOW_CYC cycles.
  - The hit counter is cleared on entry.
  - It increments on each hit-edge detect asserted during a MEAS cycle.
  - It saturates at 2^CNT_W-1; no wrap.
  - Hits outside MEAS are ignored.
- REPORT:
  - On entry: res_count = final count, res_step = step_idx, res_valid = 1.
  - res_valid and the result fields are held stable until a cycle with res_ready=1.
  - On acceptance, res_valid=0 the next cycle, then go to INC if step_idx<NUM_STEPS, else DONE.
  - res_ready=1 on the first REPORT cycle is accepted, giving a minimum REPORT dwell of 1 cycle.
  - There is no timeout; the scan stalls while res_ready=0.
- DONE: done=1, busy=0, step_idx holds NUM_STEPS. start=1 moves to CLR (clearing done); otherwise stays.
- Hit edge detect: a hit is counted when the current hit sample is 1 and the previous sample is 0. Sampling path is per HIT_SYNC_EN.
- abort=1 in any state:
  - Next state IDLE, with rst_dac=0, inc_dac=0, res_valid=0 (any pending result is dropped), step_idx=0, done=0.
  - An inc_dac pulse in progress is truncated.
  - abort and start in the same cycle: abort wins, stays IDLE.
- start while busy or in CLR..REPORT: ignored.
- rst_dac and inc_dac are never high in the same cycle.

Optional Feature:
- Macro: HIT_SYNC_EN.
- Defined: hit_in passes through a 2-flop synchroniser before the edge-detect register. Hits count 3 cycles after the hit_in rise, and only if that cycle is in MEAS.
- Undefined: hit_in drives the edge-detect register directly (must already be clk-synchronous). Latency is 1 cycle.
- Counting rules are otherwise identical.

Test Plan:
- Params NUM_STEPS=3, PULSE_W=2, SETTLE_CYC=4, WINDOW_CYC=16, res_ready tied 1, hit_in=0. Pulse start -> rst_dac high 2 cycles, then 3 inc_dac pulses each 2 high/2 low, 3 results with res_step 1,2,3 and res_count 0, then done=1, busy=0.
- Same params, 5 single-cycle hit_in pulses spaced 3 cycles apart, all landing inside MEAS of step 2 (per latency of build) -> step 2 res_count=5; steps 1 and 3 report 0.
- CNT_W=2, 10 hits in one window -> res_count=3 (saturated).
- res_ready=0 for 20 cycles during REPORT of step 1 -> res_valid, res_count and res_step stable throughout. No inc_dac in that time. Raising res_ready -> res_valid drops next cycle, then inc_dac for step 2.
- abort asserted mid-MEAS of step 2 -> next cycle IDLE with all outputs 0. A subsequent start -> fresh scan beginning with rst_dac and res_step 1.
- rst asserted during an inc_dac high pulse -> inc_dac=0 on the next edge and all outputs at reset values. start asserted in the same cycle as rst is ignored.

Source files
------------

// File: rtl/dac_scan_seq.sv
// dac_scan_seq: threshold-scan sequencer for the sigma-delta DAC.
// Pulses rst_dac once, then for each step pulses inc_dac, waits for the DAC
// to settle, counts discriminator hits over a fixed window and reports the
// count over a valid/ready handshake.
// Build option: define HIT_SYNC_EN to pass hit_in through a 2-flop
// synchroniser ahead of the edge detector.
module dac_scan_seq #(
  parameter int unsigned NUM_STEPS  = 9,
  parameter int unsigned PULSE_W    = 4,
  parameter int unsigned SETTLE_CYC = 256,
  parameter int unsigned WINDOW_CYC = 1024,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             hit_in,
  output logic             rst_dac,
  output logic             inc_dac,
  output logic [3:0]       step_idx,
  output logic [CNT_W-1:0] res_count,
  output logic [3:0]       res_step,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_INC, S_GAP, S_SETTLE, S_MEAS, S_REPORT, S_DONE
  } state_t;

  localparam int unsigned MAX_SW  = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
  localparam int unsigned MAX_LEN = (MAX_SW > PULSE_W) ? MAX_SW : PULSE_W;
  localparam int unsigned TMR_W   = $clog2(MAX_LEN + 1);

  localparam logic [TMR_W-1:0] PW_LAST = TMR_W'(PULSE_W - 1);
  localparam logic [TMR_W-1:0] ST_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] WN_LAST = TMR_W'(WINDOW_CYC - 1);
  localparam logic [3:0]       LAST_STEP = 4'(NUM_STEPS);

  state_t           state, state_nxt;
  logic             entering;
  logic [TMR_W-1:0] tmr;
  logic [CNT_W-1:0] hit_cnt, hit_sum;
  logic             hit_smp, hit_q, hit_edge;

`ifdef HIT_SYNC_EN
  logic hit_s1, hit_s2;

  // Two-flop synchroniser for an asynchronous discriminator output
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_s1 <= 1'b0;
      hit_s2 <= 1'b0;
    end else begin
      hit_s1 <= hit_in;
      hit_s2 <= hit_s1;
    end
  end

  assign hit_smp = hit_s2;
`else
  assign hit_smp = hit_in;
`endif

  // Previous hit sample for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) hit_q <= 1'b0;
    else     hit_q <= hit_smp;
  end

  assign hit_edge = hit_smp & ~hit_q;

  // Saturating increment of the hit count for the current cycle
  always_comb begin
    hit_sum = hit_cnt;
    if (hit_edge && (hit_cnt != '1)) hit_sum = hit_cnt + 1'b1;
  end

  // Next-state decode: per-state dwell timing, handshake, abort override
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_CLR;
      S_CLR:    if (tmr == PW_LAST) state_nxt = S_INC;
      S_INC:    if (tmr == PW_LAST) state_nxt = S_GAP;
      S_GAP:    if (tmr == PW_LAST) state_nxt = S_SETTLE;
      S_SETTLE: if (tmr == ST_LAST) state_nxt = S_MEAS;
      S_MEAS:   if (tmr == WN_LAST) state_nxt = S_REPORT;
      S_REPORT: if (res_ready) state_nxt = (step_idx < LAST_STEP) ? S_INC : S_DONE;
      S_DONE:   if (start) state_nxt = S_CLR;
      default:  state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  assign entering = (state_nxt != state);

  // State, dwell timer, registered strobes/status, hit counter and result
  // Outputs are decoded from the next state so each register reflects the
  // state it is in, giving glitch-free strobes that also drop on abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tmr       <= '0;
      rst_dac   <= 1'b0;
      inc_dac   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      step_idx  <= '0;
      hit_cnt   <= '0;
      res_valid <= 1'b0;
      res_count <= '0;
      res_step  <= '0;
    end else begin
      state   <= state_nxt;
      tmr     <= entering ? '0 : tmr + 1'b1;
      rst_dac <= (state_nxt == S_CLR);
      inc_dac <= (state_nxt == S_INC);
      busy    <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      done    <= (state_nxt == S_DONE);

      if ((state_nxt == S_IDLE) || (state_nxt == S_CLR))
        step_idx <= '0;
      else if ((state_nxt == S_INC) && entering)
        step_idx <= step_idx + 4'd1;

      if ((state_nxt == S_MEAS) && entering)
        hit_cnt <= '0;
      else if (state == S_MEAS)
        hit_cnt <= hit_sum;

      if ((state_nxt == S_REPORT) && entering) begin
        res_valid <= 1'b1;
        res_count <= hit_sum;
        res_step  <= step_idx;
      end else if (state_nxt != S_REPORT) begin
        res_valid <= 1'b0;
      end

      if (abort) begin
        res_count <= '0;
        res_step  <= '0;
      end
    end
  end

endmodule
